pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; generic successor to the fixed 32-bit fetch/decode register.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W-bit payload with a valid/ready handshake, synchronous flush, and saturating stall/flush event counters for performance analysis.
- Optionally adds a skid entry so the input ready is registered, with no combinational ready path from out_ready to in_ready.

Parameters:
- DATA_W, 64: payload width in bits (e.g. PC[31:0] concatenated with instr[31:0]).
- FLUSH_DATA, 0: value loaded into out_data on reset and flush; use {32'b0, 32'h00000013} for a NOP-filled IF/ID.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all held entries.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept a payload this cycle.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage holds a valid payload.
- out_ready  input  1  downstream accepts the payload this cycle.
- out_data  output  DATA_W  held payload.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_cnt  output  CNT_W  flush cycles that discarded at least one valid entry.

Behaviour:
- Reset: out_valid=0, out_data=FLUSH_DATA, stall_cnt=0, flush_cnt=0, skid entry empty.
- in_ready=1 during reset and on the first cycle after it.
- Transfers:
  - Input transfer (accept) occurs when in_valid && in_ready.
  - Output transfer (drain) occurs when out_valid && out_ready.
- Base mode (no skid), single entry:
  - in_ready = !out_valid || out_ready, combinational.
  - Accept: out_valid<=1, out_data<=in_data next cycle. Latency is one cycle.
  - Drain without accept: out_valid<=0; out_data is held (don't-care).
  - Simultaneous accept and drain: new payload replaces the old one. Full throughput, one item per cycle.
  - Neither accept nor drain: all state holds, so a stall preserves the payload exactly.
- Flush:
  - Highest priority over accept and drain.
  - Next cycle: out_valid=0, out_data=FLUSH_DATA, skid entry cleared.
  - in_data presented in the flush cycle is discarded, even if in_ready=1.
  - The upstream stage treats it as killed.
- Counters:
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Cleared only by reset.
  - stall_cnt increments in any cycle where out_valid && !out_ready && !flush.
  - flush_cnt increments when flush && (out_valid || skid_valid).
- Reset asserted mid-transfer: state clears immediately and asynchronously; the in-flight payload is lost.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - Adds one skid entry; in_ready is registered as !skid_valid.
  - States: EMPTY (out_valid=0), FULL (out_valid=1, skid=0), SKID (both valid).
  - EMPTY + accept -> FULL.
  - FULL + accept + drain -> FULL, with the new payload.
  - FULL + accept + !drain -> SKID; the new payload goes into skid.
  - FULL + drain + !accept -> EMPTY.
  - SKID + drain -> FULL; skid moves to out, and in_ready returns to 1 next cycle.
  - SKID + !drain -> SKID, holding both entries.
  - Payload order is always preserved.
  - Flush from any state -> EMPTY.
- Undefined: base single-entry mode as described above.
- Port list is identical in both modes.

Decomposition:
- Shared package pipe_pkg holds:
  - RV NOP constant NOP_INSTR = 32'h00000013.
  - Default widths PC_W=32, INSTR_W=32, PERF_CNT_W=16.
  - Typedef if_id_payload_t {pc, instr}, used to size DATA_W.
- One natural sub-module: sat_counter (CNT_W parameter; inc input; count output; saturates), instantiated twice.

Test Plan:
- Reset then in_valid=1, in_data=64'hA, out_ready=1 every cycle -> out_valid=1, out_data=64'hA one cycle later; in_ready stays 1; payloads 64'hA, 64'hB, 64'hC stream one per cycle in order.
- Load 64'h5, then hold out_ready=0 for 4 cycles with in_valid=1 -> out_data stays 64'h5; stall_cnt=4; no input is accepted in base mode.
- Same stall with PIPE_STAGE_SKID_EN, input 64'h6 -> in_ready falls after 64'h6 enters skid; out_ready=1 -> 64'h5 then 64'h6 drain on consecutive cycles; in_ready returns to 1.
- Stage valid with 64'h7, flush=1 while in_valid=1, in_data=64'h8 -> next cycle out_valid=0, out_data=FLUSH_DATA, flush_cnt=1; 64'h8 never appears; a flush with the stage empty leaves flush_cnt unchanged.
- CNT_W=3, hold the stall for 10 cycles -> stall_cnt saturates at 7 and stays at 7.
- Assert reset asynchronously mid-stall between clock edges -> out_valid=0 and counters=0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants, widths and payload types.
// Used by pipe_stage_reg and the stages around it.
package pipe_pkg;

    localparam int PC_W       = 32;
    localparam int INSTR_W    = 32;
    localparam int PERF_CNT_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

    function automatic if_id_payload_t nop_payload(
        input logic [PC_W-1:0] pc
    );
        if_id_payload_t p;
        p.pc    = pc;
        p.instr = NOP_INSTR;
        return p;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones, cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush and perf counters.
// Define PIPE_STAGE_SKID_EN for a skid entry and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = $bits(if_id_payload_t),
    parameter logic [DATA_W-1:0] FLUSH_DATA = '0,
    parameter int                CNT_W      = PERF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic accept;
    logic drain;
    logic skid_valid;
    logic stall_inc;
    logic flush_inc;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

    skid_state_e       state_q;
    skid_state_e       state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            data_q  <= FLUSH_DATA;
            skid_q  <= FLUSH_DATA;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            data_d  = FLUSH_DATA;
            skid_d  = FLUSH_DATA;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        data_d  = in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        data_d = in_data;
                    end else if (accept) begin
                        state_d = ST_SKID;
                        skid_d  = in_data;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only a drain can move us
                    if (drain) begin
                        state_d = ST_FULL;
                        data_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign out_valid  = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_SKID);
    assign in_ready   = !skid_valid;
    assign out_data   = data_q;

`else

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= FLUSH_DATA;
        end else if (flush) begin
            valid_q <= 1'b0;
            data_q  <= FLUSH_DATA;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign skid_valid = 1'b0;
    assign in_ready   = !valid_q || out_ready;
    assign out_data   = data_q;

`endif

    assign stall_inc = out_valid && !out_ready && !flush;
    assign flush_inc = flush && (out_valid || skid_valid);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule
